// File: rtl/mips_pkg.sv
// Shared widths, FSM state encoding and retire classification helper for
// the retire/commit slice.
package mips_pkg;

  localparam int TAG_W  = 5;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // Legacy-compatible state encoding for the retire_commit FSM.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef enum logic [1:0] {
    RK_REG    = 2'd0,
    RK_STORE  = 2'd1,
    RK_BRANCH = 2'd2
  } retire_kind_t;

  // Store takes priority over branch; anything else is a register write.
  function automatic retire_kind_t classify(input logic is_store,
                                            input logic is_branch);
    if (is_store)       return RK_STORE;
    else if (is_branch) return RK_BRANCH;
    else                return RK_REG;
  endfunction

endpackage

// File: rtl/retire_commit_if.sv
// Retire-side bundle of retire_commit: ROB retire inputs, register-file,
// store-commit, flush, free-tag return and statistics outputs.
//   master : the environment (ROB, RF, store queue, fetch, allocator)
//   slave  : retire_commit
interface retire_commit_if #(
  parameter int CNT_W = 32
);
  import mips_pkg::*;

  logic [TAG_W-1:0]  Retire_rd_tag;
  logic [REG_W-1:0]  Retire_rd_reg;
  logic [DATA_W-1:0] Retire_data;
  logic [DATA_W-1:0] Retire_pc;
  logic              Retire_branch;
  logic              Retire_branch_taken;
  logic              Retire_store_ready;
  logic              Retire_valid;
  logic              Retire_stall;
  logic              Rf_wen;
  logic [REG_W-1:0]  Rf_waddr;
  logic [DATA_W-1:0] Rf_wdata;
  logic              Store_commit;
  logic [TAG_W-1:0]  Store_commit_tag;
  logic              Flush;
  logic [DATA_W-1:0] Flush_pc;
  logic [TAG_W-1:0]  Tag_free;
  logic              Tag_free_valid;
  logic              Tag_free_ready;
  logic              Retire_err;
  logic [CNT_W-1:0]  Retired_count;
  logic [CNT_W-1:0]  Mispredict_count;

  modport master (
    output Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
           Retire_branch, Retire_branch_taken, Retire_store_ready,
           Retire_valid, Tag_free_ready,
    input  Retire_stall, Rf_wen, Rf_waddr, Rf_wdata, Store_commit,
           Store_commit_tag, Flush, Flush_pc, Tag_free, Tag_free_valid,
           Retire_err, Retired_count, Mispredict_count
  );

  modport slave (
    input  Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
           Retire_branch, Retire_branch_taken, Retire_store_ready,
           Retire_valid, Tag_free_ready,
    output Retire_stall, Rf_wen, Rf_waddr, Rf_wdata, Store_commit,
           Store_commit_tag, Flush, Flush_pc, Tag_free, Tag_free_valid,
           Retire_err, Retired_count, Mispredict_count
  );

endinterface

// File: rtl/retire_commit_tag_return_fifo.sv
// First-word-fall-through FIFO returning retired tags to the allocator.
//   clock, reset : clock, async active-high reset (empties the FIFO)
//   push, push_data : write one entry (caller guarantees !full)
//   pop_req      : consume head; ignored while empty
//   head         : head entry, 0 while empty
//   empty, full  : occupancy flags
module tag_return_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_req,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = pop_req && !empty;
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; head is masked while empty instead.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/retire_commit.sv
// Consumer of the ROB retire stream. Each accepted retire either writes the
// register file, commits a store, or (taken branch) issues a one-cycle flush
// followed by a drain window; every accepted tag is returned through a FIFO.
//   clock, reset : clock, async active-high reset
//   rif          : retire_commit_if slave (all retire/commit/tag signals)
module retire_commit
  import mips_pkg::*;
#(
  parameter int TAGQ_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic          clock,
  input  logic          reset,
  retire_commit_if.slave rif
);

  localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]        state_q;
  logic [DW-1:0]     drain_q;
  logic              fifo_full, fifo_empty;
  logic              stall, accept, do_flush;
  retire_kind_t      kind;

  logic              rf_wen_q, sc_q, flush_q, err_q;
  logic [REG_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q, flush_pc_q;
  logic [TAG_W-1:0]  sc_tag_q;
  logic [CNT_W-1:0]  retired_q, mispredict_q;

  assign stall    = (state_q != IDLE) || fifo_full;
  assign accept   = rif.Retire_valid && !stall;
  assign kind     = classify(rif.Retire_store_ready, rif.Retire_branch);
  assign do_flush = accept && (kind == RK_BRANCH) && rif.Retire_branch_taken;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE:  if (do_flush) state_q <= FLUSH;
        FLUSH: begin
          if (FLUSH_CYCLES == 0) begin
            state_q <= IDLE;
          end else begin
            state_q <= DRAIN;
            drain_q <= DW'(FLUSH_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_q == '0) state_q <= IDLE;
          else               drain_q <= drain_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      sc_q         <= 1'b0;
      sc_tag_q     <= '0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
      err_q        <= 1'b0;
      retired_q    <= '0;
      mispredict_q <= '0;
    end else begin
      rf_wen_q <= accept && (kind == RK_REG) && (rif.Retire_rd_reg != '0);
      sc_q     <= accept && (kind == RK_STORE);
      flush_q  <= do_flush;
      if (accept && (kind == RK_REG)) begin
        rf_waddr_q <= rif.Retire_rd_reg;
        rf_wdata_q <= rif.Retire_data;
      end
      if (accept && (kind == RK_STORE)) sc_tag_q <= rif.Retire_rd_tag;
      if (do_flush) begin
        flush_pc_q   <= rif.Retire_pc;
        mispredict_q <= mispredict_q + 1'b1;
      end
      if (accept) retired_q <= retired_q + 1'b1;
      if (rif.Retire_valid && stall) err_q <= 1'b1;
    end
  end

  tag_return_fifo #(
    .DEPTH (TAGQ_DEPTH),
    .W     (TAG_W)
  ) u_tagq (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (rif.Retire_rd_tag),
    .pop_req   (rif.Tag_free_ready),
    .head      (rif.Tag_free),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rif.Tag_free_valid   = !fifo_empty;
  assign rif.Retire_stall     = stall;
  assign rif.Rf_wen           = rf_wen_q;
  assign rif.Rf_waddr         = rf_waddr_q;
  assign rif.Rf_wdata         = rf_wdata_q;
  assign rif.Store_commit     = sc_q;
  assign rif.Store_commit_tag = sc_tag_q;
  assign rif.Flush            = flush_q;
  assign rif.Flush_pc         = flush_pc_q;
  assign rif.Retire_err       = err_q;
  assign rif.Retired_count    = retired_q;
  assign rif.Mispredict_count = mispredict_q;

endmodule

// File: tb/tb_retire_commit.sv
module tb_retire_commit;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  retire_commit_if #(.CNT_W(32)) ifc ();

  retire_commit #(
    .TAGQ_DEPTH   (4),
    .FLUSH_CYCLES (2),
    .CNT_W        (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rif   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [4:0]  tag;
    logic [4:0]  rreg;
    logic [31:0] data;
    logic [31:0] pc;
    logic        br;
    logic        tk;
    logic        st;
    logic        rdy;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_sc;
    logic [4:0]  e_sctag;
    logic        e_flush;
    logic        e_stall;
    logic        e_tfv;
    logic [4:0]  e_tf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] tag,
                       input logic [4:0] rreg, input logic [31:0] data,
                       input logic [31:0] pc, input logic br, input logic tk,
                       input logic st, input logic rdy);
    ifc.Retire_valid        = v;
    ifc.Retire_rd_tag       = tag;
    ifc.Retire_rd_reg       = rreg;
    ifc.Retire_data         = data;
    ifc.Retire_pc           = pc;
    ifc.Retire_branch       = br;
    ifc.Retire_branch_taken = tk;
    ifc.Retire_store_ready  = st;
    ifc.Tag_free_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_stall"},   32'(ifc.Retire_stall), 32'h0);
    chk({pfx, "_rf_wen"},  32'(ifc.Rf_wen), 32'h0);
    chk({pfx, "_waddr"},   32'(ifc.Rf_waddr), 32'h0);
    chk({pfx, "_wdata"},   ifc.Rf_wdata, 32'h0);
    chk({pfx, "_sc"},      32'(ifc.Store_commit), 32'h0);
    chk({pfx, "_sctag"},   32'(ifc.Store_commit_tag), 32'h0);
    chk({pfx, "_flush"},   32'(ifc.Flush), 32'h0);
    chk({pfx, "_flushpc"}, ifc.Flush_pc, 32'h0);
    chk({pfx, "_tf"},      32'(ifc.Tag_free), 32'h0);
    chk({pfx, "_tfv"},     32'(ifc.Tag_free_valid), 32'h0);
    chk({pfx, "_err"},     32'(ifc.Retire_err), 32'h0);
    chk({pfx, "_retired"}, ifc.Retired_count, 32'h0);
    chk({pfx, "_mispred"}, ifc.Mispredict_count, 32'h0);
  endtask

  initial begin
    logic [4:0] exp_tags [3];
    checks = 0;
    errors = 0;

    //          valid tag    rreg   data          pc            br   tk   st   rdy
    //          | wen waddr  wdata         sc   sctag  flush stall tfv  tf
    tbl[0] = '{1'b1, 5'd3,  5'd7, 32'hDEADBEEF, 32'h0,        1'b0,1'b0,1'b0,1'b0,
               1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd3};
    tbl[1] = '{1'b1, 5'd4,  5'd0, 32'h00001234, 32'h0,        1'b0,1'b0,1'b0,1'b1,
               1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd4};
    tbl[2] = '{1'b1, 5'd9,  5'd2, 32'h0000BEEF, 32'h0,        1'b0,1'b0,1'b1,1'b1,
               1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 5'd9};
    tbl[3] = '{1'b0, 5'd0,  5'd0, 32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b1,
               1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[4] = '{1'b1, 5'd5,  5'd6, 32'h00000055, 32'h00001000, 1'b1,1'b0,1'b0,1'b0,
               1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd5};
    tbl[5] = '{1'b0, 5'd0,  5'd0, 32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b1,
               1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[6] = '{1'b1, 5'd13, 5'd3, 32'h0,        32'h00002000, 1'b1,1'b1,1'b1,1'b0,
               1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 1'b0, 1'b0, 1'b1, 5'd13};
    tbl[7] = '{1'b0, 5'd0,  5'd0, 32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b1,
               1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0};

    reset = 1'b1;
    idle(1'b0);
    tick();
    tick();
    chk_all_zero("rst");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].valid, tbl[i].tag, tbl[i].rreg, tbl[i].data, tbl[i].pc,
            tbl[i].br, tbl[i].tk, tbl[i].st, tbl[i].rdy);
      tick();
      chk($sformatf("v%0d_wen", i),   32'(ifc.Rf_wen), 32'(tbl[i].e_wen));
      if (tbl[i].e_wen) begin
        chk($sformatf("v%0d_waddr", i), 32'(ifc.Rf_waddr), 32'(tbl[i].e_waddr));
        chk($sformatf("v%0d_wdata", i), ifc.Rf_wdata, tbl[i].e_wdata);
      end
      chk($sformatf("v%0d_sc", i),    32'(ifc.Store_commit), 32'(tbl[i].e_sc));
      if (tbl[i].e_sc)
        chk($sformatf("v%0d_sctag", i), 32'(ifc.Store_commit_tag), 32'(tbl[i].e_sctag));
      chk($sformatf("v%0d_flush", i), 32'(ifc.Flush), 32'(tbl[i].e_flush));
      chk($sformatf("v%0d_stall", i), 32'(ifc.Retire_stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_tfv", i),   32'(ifc.Tag_free_valid), 32'(tbl[i].e_tfv));
      chk($sformatf("v%0d_tf", i),    32'(ifc.Tag_free), 32'(tbl[i].e_tf));
    end
    chk("tbl_retired", ifc.Retired_count, 32'd5);
    chk("tbl_mispred", ifc.Mispredict_count, 32'd0);
    chk("tbl_err", 32'(ifc.Retire_err), 32'd0);

    // Taken branch: flush pulse, three stalled cycles, ignored retire.
    drive(1'b1, 5'd12, 5'd9, 32'h77, 32'h00400040, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("br_flush", 32'(ifc.Flush), 32'd1);
    chk("br_flushpc", ifc.Flush_pc, 32'h00400040);
    chk("br_stall1", 32'(ifc.Retire_stall), 32'd1);
    chk("br_mispred", ifc.Mispredict_count, 32'd1);
    chk("br_retired", ifc.Retired_count, 32'd6);
    chk("br_rfwen", 32'(ifc.Rf_wen), 32'd0);
    chk("br_tf", 32'(ifc.Tag_free), 32'd12);
    drive(1'b1, 5'd20, 5'd8, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_flush_once", 32'(ifc.Flush), 32'd0);
    chk("br_stall2", 32'(ifc.Retire_stall), 32'd1);
    chk("br_err", 32'(ifc.Retire_err), 32'd1);
    chk("br_ign_rfwen", 32'(ifc.Rf_wen), 32'd0);
    chk("br_ign_retired", ifc.Retired_count, 32'd6);
    idle(1'b0);
    tick();
    chk("br_stall3", 32'(ifc.Retire_stall), 32'd1);
    tick();
    chk("br_stall_end", 32'(ifc.Retire_stall), 32'd0);
    chk("br_mispred_hold", ifc.Mispredict_count, 32'd1);
    idle(1'b1);
    tick();
    chk("br_ign_notpushed", 32'(ifc.Tag_free_valid), 32'd0);
    chk("br_err_sticky", 32'(ifc.Retire_err), 32'd1);

    // Fill the tag FIFO with the allocator stalled.
    for (int t = 1; t <= 4; t++) begin
      drive(1'b1, 5'(t), 5'(t), 32'(t), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk($sformatf("fill%0d_stall", t), 32'(ifc.Retire_stall), (t == 4) ? 32'd1 : 32'd0);
    end
    chk("fill_tf", 32'(ifc.Tag_free), 32'd1);
    chk("fill_retired", ifc.Retired_count, 32'd10);
    idle(1'b1);
    tick();
    chk("pop1_tf", 32'(ifc.Tag_free), 32'd2);
    chk("pop1_stall", 32'(ifc.Retire_stall), 32'd0);
    drive(1'b1, 5'd6, 5'd1, 32'h6, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pushpop_tf", 32'(ifc.Tag_free), 32'd3);
    chk("pushpop_stall", 32'(ifc.Retire_stall), 32'd0);
    drive(1'b1, 5'd7, 5'd1, 32'h7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("refill_stall", 32'(ifc.Retire_stall), 32'd1);
    chk("refill_tf", 32'(ifc.Tag_free), 32'd3);
    exp_tags[0] = 5'd4;
    exp_tags[1] = 5'd6;
    exp_tags[2] = 5'd7;
    idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("drain%0d_tf", k), 32'(ifc.Tag_free), 32'(exp_tags[k]));
    end
    tick();
    chk("drain_empty", 32'(ifc.Tag_free_valid), 32'd0);
    chk("drain_retired", ifc.Retired_count, 32'd12);

    // Reset during DRAIN with two tags queued.
    drive(1'b1, 5'd10, 5'd5, 32'hAA, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd11, 5'd0, 32'h0, 32'h00500000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    tick();
    chk("pre_rst_stall", 32'(ifc.Retire_stall), 32'd1);
    chk("pre_rst_tfv", 32'(ifc.Tag_free_valid), 32'd1);
    reset = 1'b1;
    #2;
    chk_all_zero("arst");
    reset = 1'b0;
    tick();
    chk_all_zero("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
